// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg
// Shared definitions for the multi-channel signed MAC:
//   - mode_t     : per-beat accumulator operation (ADD, SUB, LOAD, CLEAR)
//   - ch_width() : channel index width, max(1, clog2(num_ch))
//   - sat_max()  : most positive signed value for a given width (LSB-aligned)
//   - sat_min()  : most negative signed value for a given width (LSB-aligned)
// The limit helpers return a wide vector; callers truncate to their width.
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_SUB   = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_t;

  localparam int LIMIT_W = 128;

  function automatic int ch_width(input int num_ch);
    if (num_ch <= 2) begin
      return 1;
    end else begin
      return $clog2(num_ch);
    end
  endfunction

  function automatic logic [LIMIT_W-1:0] sat_max(input int width);
    return (LIMIT_W'(1) << (width - 1)) - LIMIT_W'(1);
  endfunction

  // Bitwise inverse of 2^(w-1)-1; its low w bits are 1000...0.
  function automatic logic [LIMIT_W-1:0] sat_min(input int width);
    return ~sat_max(width);
  endfunction

endpackage

// File: rtl/dsp_mac_acc_unit.sv
// dsp_mac_acc_unit
// Combinational accumulator update for one beat.
// Ports:
//   acc    in  ACC_WIDTH  current accumulator value (signed)
//   prod   in  ACC_WIDTH  sign-extended product (signed)
//   mode   in  mode_t     ADD / SUB / LOAD / CLEAR
//   result out ACC_WIDTH  new accumulator value
//   ovf    out 1          signed overflow on ADD/SUB, 0 for LOAD/CLEAR
// Optional feature: define DSP_MAC_SAT_EN to clamp overflowing ADD/SUB
// results to the signed limits; otherwise the result wraps.
module dsp_mac_acc_unit
  import dsp_mac_pkg::*;
#(
  parameter int ACC_WIDTH = 48
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [ACC_WIDTH-1:0] prod,
  input  mode_t                mode,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 ovf
);

`ifdef DSP_MAC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] POS_LIM = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] NEG_LIM = ACC_WIDTH'(sat_min(ACC_WIDTH));
`endif

  // One guard bit: the true sum/difference always fits in ACC_WIDTH+1 bits.
  logic [ACC_WIDTH:0] ext_sum;
  logic               arith;

  // Extended-precision add/subtract for the arithmetic modes.
  always_comb begin
    ext_sum = '0;
    arith   = 1'b0;
    case (mode)
      MODE_ADD: begin
        ext_sum = {acc[ACC_WIDTH-1], acc} + {prod[ACC_WIDTH-1], prod};
        arith   = 1'b1;
      end
      MODE_SUB: begin
        ext_sum = {acc[ACC_WIDTH-1], acc} - {prod[ACC_WIDTH-1], prod};
        arith   = 1'b1;
      end
      MODE_LOAD, MODE_CLEAR: begin
        ext_sum = '0;
        arith   = 1'b0;
      end
      default: begin
        ext_sum = '0;
        arith   = 1'b0;
      end
    endcase
  end

  // Result selection; guard bit differing from the sign bit means overflow.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    if (arith) begin
      ovf = ext_sum[ACC_WIDTH] ^ ext_sum[ACC_WIDTH-1];
`ifdef DSP_MAC_SAT_EN
      if (ovf) begin
        result = ext_sum[ACC_WIDTH] ? NEG_LIM : POS_LIM;
      end else begin
        result = ext_sum[ACC_WIDTH-1:0];
      end
`else
      result = ext_sum[ACC_WIDTH-1:0];
`endif
    end else if (mode == MODE_LOAD) begin
      result = prod;
    end else begin
      result = '0;
    end
  end

endmodule

// File: rtl/dsp_mac_multichannel_accum.sv
// dsp_mac_multichannel_accum
// Three-stage pipelined signed MAC with NUM_CH independent accumulators.
//   stage 1: register operands, channel, mode, valid
//   stage 2: register full-precision product, sign-extended to ACC_WIDTH
//   stage 3: read/modify/write acc[ch], register P, ch_o, ovf_o, valid_o
// Ports:
//   clk, reset (async, active-low)
//   valid_i, ch_i[CH_W], mode_i[2], A[A_WIDTH], B[B_WIDTH]   input beat
//   P[ACC_WIDTH], ch_o[CH_W], valid_o, ovf_o                 result
// Optional feature: DSP_MAC_SAT_EN selects saturating ADD/SUB.
module dsp_mac_multichannel_accum
  import dsp_mac_pkg::*;
#(
  parameter  int A_WIDTH   = 20,
  parameter  int B_WIDTH   = 18,
  parameter  int ACC_WIDTH = 48,
  parameter  int NUM_CH    = 4,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_i,
  input  logic [CH_W-1:0]             ch_i,
  input  logic [1:0]                  mode_i,
  input  logic signed [A_WIDTH-1:0]   A,
  input  logic signed [B_WIDTH-1:0]   B,
  output logic signed [ACC_WIDTH-1:0] P,
  output logic [CH_W-1:0]             ch_o,
  output logic                        valid_o,
  output logic                        ovf_o
);

  localparam int PROD_W = A_WIDTH + B_WIDTH;

  if (ACC_WIDTH < PROD_W) begin : g_acc_width_check
    $error("dsp_mac_multichannel_accum: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end
  if (NUM_CH < 1) begin : g_num_ch_check
    $error("dsp_mac_multichannel_accum: NUM_CH must be >= 1");
  end

  logic                        s1_valid;
  logic [CH_W-1:0]             s1_ch;
  mode_t                       s1_mode;
  logic signed [A_WIDTH-1:0]   s1_a;
  logic signed [B_WIDTH-1:0]   s1_b;

  logic                        s2_valid;
  logic [CH_W-1:0]             s2_ch;
  mode_t                       s2_mode;
  logic [ACC_WIDTH-1:0]        s2_prod;

  logic signed [PROD_W-1:0]    full_prod;
  logic [ACC_WIDTH-1:0]        acc_bank [NUM_CH];
  logic [ACC_WIDTH-1:0]        acc_rd;
  logic [ACC_WIDTH-1:0]        acc_nxt;
  logic                        acc_ovf;
  logic                        ch_ok;
  logic                        write_en;

  assign full_prod = s1_a * s1_b;

  // Stage 1 and stage 2 pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_mode  <= MODE_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_ch    <= '0;
      s2_mode  <= MODE_ADD;
      s2_prod  <= '0;
    end else begin
      s1_valid <= valid_i;
      s1_ch    <= ch_i;
      s1_mode  <= mode_t'(mode_i);
      s1_a     <= A;
      s1_b     <= B;
      s2_valid <= s1_valid;
      s2_ch    <= s1_ch;
      s2_mode  <= s1_mode;
      s2_prod  <= ACC_WIDTH'(full_prod);
    end
  end

  // Extra leading zero keeps the compare correct when NUM_CH == 2**CH_W.
  assign ch_ok    = ({1'b0, s2_ch} < (CH_W + 1)'(NUM_CH));
  assign write_en = s2_valid & ch_ok;

  // Bank read; an out-of-range channel never reaches the array index.
  always_comb begin
    acc_rd = '0;
    if (ch_ok) begin
      acc_rd = acc_bank[s2_ch];
    end else begin
      acc_rd = '0;
    end
  end

  dsp_mac_acc_unit #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc_unit (
    .acc    (acc_rd),
    .prod   (s2_prod),
    .mode   (s2_mode),
    .result (acc_nxt),
    .ovf    (acc_ovf)
  );

  // Accumulator bank; written on the same edge that registers P, so a
  // following beat on the same channel reads the fresh value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_bank[i] <= '0;
      end
    end else if (write_en) begin
      acc_bank[s2_ch] <= acc_nxt;
    end
  end

  // Result registers; P/ch_o/ovf_o hold between valid results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      P       <= '0;
      ch_o    <= '0;
      ovf_o   <= 1'b0;
      valid_o <= 1'b0;
    end else if (write_en) begin
      P       <= acc_nxt;
      ch_o    <= s2_ch;
      ovf_o   <= acc_ovf;
      valid_o <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end

endmodule
